// File: rtl/sme_pkg.sv
// Shared types and constants for the string-matching-engine host driver.
package sme_pkg;

  localparam int unsigned STR_MAX_DEF     = 32;
  localparam int unsigned PAT_MAX_DEF     = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 128;

  // Pattern metacharacters; the driver forwards them untouched, the engine interprets them.
  localparam logic [7:0] CH_HEAD = 8'h5E;
  localparam logic [7:0] CH_TAIL = 8'h24;
  localparam logic [7:0] CH_ANY  = 8'h2E;
  localparam logic [7:0] CH_STAR = 8'h2A;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StSendPat,
    StWaitRes,
    StDone
  } sme_state_e;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: register file, saturating length counter and sticky overflow flag.
module sme_char_buf #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LW = $clog2(DEPTH + 1),
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          clr,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len,
  output logic          ovf
);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q;
  logic          ovf_q;
  logic          full;
  logic          push;

  assign full = (len_q == LW'(DEPTH));
  assign push = wr_en && !clr && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (wr_en) begin
      if (full) ovf_q <= 1'b1;
      else      len_q <= len_q + 1'b1;
    end
  end

  // Contents need no reset: len gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[len_q[IW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];
  assign len     = len_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/sme_host_driver.sv
// Host-side transmitter for the string-matching engine; streams string/pattern, returns result.
// Define SME_DRV_TIMEOUT_EN to add the result watchdog (TIMEOUT_CYC cycles in WAIT_RES).
module sme_host_driver
  import sme_pkg::*;
#(
  parameter int unsigned STR_MAX = STR_MAX_DEF,
  parameter int unsigned PAT_MAX = PAT_MAX_DEF
`ifdef SME_DRV_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       clr_str,
  input  logic       clr_pat,
  input  logic       start,
  input  logic       send_str,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic       ovf,
  output logic       result_match,
  output logic [4:0] result_index,
  output logic       timeout,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index
);

  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned SIW = $clog2(STR_MAX);
  localparam int unsigned PIW = $clog2(PAT_MAX);

  sme_state_e     state_q, state_d;
  logic [SLW-1:0] idx_q, idx_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic           busy_q, busy_d, done_q, done_d, cmd_err_q, cmd_err_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;

  logic           idle, wr_ok;
  logic [SLW-1:0] str_len;
  logic [PLW-1:0] pat_len;
  logic [7:0]     str_rd_data, pat_rd_data;
  logic           str_ovf, pat_ovf;
  logic [SIW-1:0] str_rd_idx;
  logic [PIW-1:0] pat_rd_idx;

  assign idle  = (state_q == StIdle);
  // start wins over a same-cycle write
  assign wr_ok = idle && wr_en && !start;
  // Index 0 is presented outside the sending state so the first char is ready on entry.
  assign str_rd_idx = (state_q == StSendStr) ? idx_q[SIW-1:0] : '0;
  assign pat_rd_idx = (state_q == StSendPat) ? idx_q[PIW-1:0] : '0;

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && !wr_sel),
    .clr     (idle && clr_str),
    .wr_data (wr_data),
    .rd_idx  (str_rd_idx),
    .rd_data (str_rd_data),
    .len     (str_len),
    .ovf     (str_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && wr_sel),
    .clr     (idle && clr_pat),
    .wr_data (wr_data),
    .rd_idx  (pat_rd_idx),
    .rd_data (pat_rd_data),
    .len     (pat_len),
    .ovf     (pat_ovf)
  );

`ifdef SME_DRV_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chardata_d  = 8'h00;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    done_d      = 1'b0;
    cmd_err_d   = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
`ifdef SME_DRV_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (pat_len == '0 || (send_str && str_len == '0)) begin
            cmd_err_d = 1'b1;
          end else begin
            res_match_d = 1'b0;
            res_index_d = '0;
`ifdef SME_DRV_TIMEOUT_EN
            timeout_d   = 1'b0;
`endif
            idx_d = SLW'(1);
            if (send_str) begin
              state_d    = StSendStr;
              chardata_d = str_rd_data;
              isstring_d = 1'b1;
            end else begin
              state_d     = StSendPat;
              chardata_d  = pat_rd_data;
              ispattern_d = 1'b1;
            end
          end
        end
      end
      StSendStr: begin
        // idx_q counts chars already presented; at str_len the pattern follows with no gap.
        if (idx_q == str_len) begin
          state_d     = StSendPat;
          chardata_d  = pat_rd_data;
          ispattern_d = 1'b1;
          idx_d       = SLW'(1);
        end else begin
          chardata_d = str_rd_data;
          isstring_d = 1'b1;
          idx_d      = idx_q + 1'b1;
        end
      end
      StSendPat: begin
        if (idx_q == SLW'(pat_len)) begin
          state_d = StWaitRes;
          idx_d   = '0;
`ifdef SME_DRV_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          chardata_d  = pat_rd_data;
          ispattern_d = 1'b1;
          idx_d       = idx_q + 1'b1;
        end
      end
      StWaitRes: begin
        if (sme_valid) begin
          state_d     = StDone;
          done_d      = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_match_index;
`ifdef SME_DRV_TIMEOUT_EN
        end else if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = StDone;
          done_d      = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          timeout_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      chardata_q  <= 8'h00;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
    end
  end

`ifdef SME_DRV_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd_err      = cmd_err_q;
  assign ovf          = str_ovf | pat_ovf;
  assign result_match = res_match_q;
  assign result_index = res_index_q;
  assign chardata     = chardata_q;
  assign isstring     = isstring_q;
  assign ispattern    = ispattern_q;

endmodule

// File: tb/tb_sme_host_driver.sv
// Scoreboard bench for sme_host_driver: stimulus pushes expected chars/results, monitor pops.
module tb_sme_host_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, clr_str, clr_pat, start, send_str;
  logic [7:0] wr_data;
  logic       busy, done, cmd_err, ovf, result_match, timeout;
  logic [4:0] result_index;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_match_index;

  always #5 clk = ~clk;

  sme_host_driver dut (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (wr_en),
    .wr_sel          (wr_sel),
    .wr_data         (wr_data),
    .clr_str         (clr_str),
    .clr_pat         (clr_pat),
    .start           (start),
    .send_str        (send_str),
    .busy            (busy),
    .done            (done),
    .cmd_err         (cmd_err),
    .ovf             (ovf),
    .result_match    (result_match),
    .result_index    (result_index),
    .timeout         (timeout),
    .chardata        (chardata),
    .isstring        (isstring),
    .ispattern       (ispattern),
    .sme_valid       (sme_valid),
    .sme_match       (sme_match),
    .sme_match_index (sme_match_index)
  );

  typedef struct {
    logic       is_str;
    logic [7:0] data;
    int         cyc;
  } char_t;

  typedef struct {
    logic       match;
    logic [4:0] index;
    logic       tmo;
    int         cyc;
  } res_t;

  char_t char_q[$];
  res_t  res_q[$];
  int    err_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (!reset) begin
      char_t ce;
      res_t  re;
      int    ec;
      check("strobe_exclusive", {31'd0, isstring & ispattern}, 0);
      if (isstring || ispattern) begin
        if (char_q.size() == 0) begin
          check("char_unexpected", {22'd0, isstring, ispattern, chardata}, 0);
        end else begin
          ce = char_q.pop_front();
          check("char_kind", {31'd0, isstring}, {31'd0, ce.is_str});
          check("char_data", {24'd0, chardata}, {24'd0, ce.data});
          check("char_cycle", cyc, ce.cyc);
        end
      end else begin
        check("idle_chardata", {24'd0, chardata}, 0);
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 0);
        end else begin
          re = res_q.pop_front();
          check("result_match", {31'd0, result_match}, {31'd0, re.match});
          check("result_index", {27'd0, result_index}, {27'd0, re.index});
          check("result_timeout", {31'd0, timeout}, {31'd0, re.tmo});
          check("done_cycle", cyc, re.cyc);
        end
      end
      if (cmd_err) begin
        if (err_q.size() == 0) begin
          check("cmd_err_unexpected", {31'd0, cmd_err}, 0);
        end else begin
          ec = err_q.pop_front();
          check("cmd_err_cycle", cyc, ec);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_char(input logic sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_buf(input logic sel, input string s);
    for (int i = 0; i < s.len(); i++) wr_char(sel, s[i]);
  endtask

  task automatic clear(input logic cs, input logic cp);
    clr_str = cs; clr_pat = cp;
    tick();
    clr_str = 1'b0; clr_pat = 1'b0;
  endtask

  // Pushes the expected char stream, then issues start; char 0 is due the cycle after.
  task automatic do_start(input logic snd, input string s, input string p);
    int base;
    base = cyc + 1;
    if (snd) begin
      for (int i = 0; i < s.len(); i++) char_q.push_back('{1'b1, s[i], base + i});
      base = base + s.len();
    end
    for (int j = 0; j < p.len(); j++) char_q.push_back('{1'b0, p[j], base + j});
    start = 1'b1; send_str = snd;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
  endtask

  task automatic expect_reject(input logic snd);
    err_q.push_back(cyc + 1);
    start = 1'b1; send_str = snd;
    tick();
    start = 1'b0;
    check("reject_busy", {31'd0, busy}, 0);
    tick();
    check("reject_busy_later", {31'd0, busy}, 0);
  endtask

  task automatic wait_res(output int entry);
    logic found;
    found = 1'b0;
    entry = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (busy && !isstring && !ispattern) begin
        found = 1'b1;
        entry = cyc;
      end else begin
        tick();
      end
    end
    check("wait_res_reached", {31'd0, found}, 1);
  endtask

  task automatic finish_txn(input logic m, input logic [4:0] idx);
    int e;
    wait_res(e);
    tick();
    tick();
    sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
    res_q.push_back('{m, idx, 1'b0, cyc + 1});
    tick();
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    check("busy_in_done", {31'd0, busy}, 1);
    tick();
    check("busy_after_done", {31'd0, busy}, 0);
    check("result_hold_match", {31'd0, result_match}, {31'd0, m});
    check("result_hold_index", {27'd0, result_index}, {27'd0, idx});
  endtask

  initial begin
    string big;
    int    e;
    logic  found;
    reset = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; clr_str = 1'b0; clr_pat = 1'b0;
    start = 1'b0; send_str = 1'b0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
    tick();
    tick();
    check("reset_outputs", {8'd0, busy, done, cmd_err, ovf, result_match, result_index, timeout,
                            chardata, isstring, ispattern}, 0);
    reset = 1'b0;
    tick();

    // 1: string "ABCD", pattern "BC"
    write_buf(1'b0, "ABCD");
    write_buf(1'b1, "BC");
    do_start(1'b1, "ABCD", "BC");
    finish_txn(1'b1, 5'd1);

    // 2: pattern only, with an anchor metacharacter
    clear(1'b0, 1'b1);
    write_buf(1'b1, "^A");
    do_start(1'b0, "", "^A");
    finish_txn(1'b1, 5'd0);

    // 4: start+write in the same idle cycle drops the write; start mid-pattern is ignored
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 8'h5A;
    do_start(1'b0, "", "^A");
    wr_en = 1'b0;
    start = 1'b1; send_str = 1'b1;
    tick();
    start = 1'b0;
    finish_txn(1'b0, 5'd3);
    do_start(1'b0, "", "^A");
    finish_txn(1'b1, 5'd7);

    // 3: string overflow, full-length send, then reject on an empty string
    clear(1'b1, 1'b0);
    big = "";
    for (int i = 0; i < 33; i++) begin
      big = {big, "x"};
      big[i] = 8'h61 + 8'(i);
    end
    for (int i = 0; i < 32; i++) wr_char(1'b0, big[i]);
    check("ovf_at_full", {31'd0, ovf}, 0);
    wr_char(1'b0, big[32]);
    check("ovf_after_drop", {31'd0, ovf}, 1);
    do_start(1'b1, big.substr(0, 31), "^A");
    finish_txn(1'b1, 5'd31);
    check("ovf_sticky", {31'd0, ovf}, 1);
    clear(1'b1, 1'b0);
    check("ovf_cleared", {31'd0, ovf}, 0);
    expect_reject(1'b1);
    clear(1'b0, 1'b1);
    expect_reject(1'b0);

    // 5: no valid from the engine
    write_buf(1'b0, "ABCD");
    write_buf(1'b1, "BC");
    do_start(1'b0, "", "BC");
    wait_res(e);
`ifdef SME_DRV_TIMEOUT_EN
    res_q.push_back('{1'b0, 5'd0, 1'b1, e + 128});
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("timeout_done_seen", {31'd0, found}, 1);
    tick();
    check("timeout_busy_after", {31'd0, busy}, 0);
`else
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!busy) found = 1'b1;
    end
    check("no_timeout_busy_dropped", {31'd0, found}, 0);
    check("no_timeout_busy", {31'd0, busy}, 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // 6: reset during the third string char
    write_buf(1'b0, "ABCD");
    write_buf(1'b1, "BC");
    do_start(1'b1, "ABCD", "BC");
    tick();
    tick();
    check("third_char_strobe", {31'd0, isstring}, 1);
    reset = 1'b1;
    #1;
    check("reset_strobes", {22'd0, isstring, ispattern, chardata}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    char_q.delete();
    tick();
    reset = 1'b0;
    tick();
    expect_reject(1'b1);
    expect_reject(1'b0);

    tick();
    tick();
    check("char_q_drained", char_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
